mem_arbiter_2to1: RTL and testbench

- Shares one 16-bit-word backing memory (5-bit word address, level rd/wr request, single-cycle mem_done) between two cache controllers.
- Each cache's memory-side port connects to one requester port; the arbiter's downstream port connects to the memory.
- Round-robin arbitration with one transaction in flight; the grant is locked until mem_done.
- Includes a watchdog that flags a memory that never completes.

---
 rtl/mem_arbiter_2to1.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter_2to1.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2to1.sv
// Round-robin arbiter that shares one 16-bit word memory between two cache controllers.
// One transaction is in flight at a time, and the grant stays locked until mem_done.
module mem_arbiter_2to1 #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c0_mem_rd,
  input  logic             c0_mem_wr,
  input  logic [4:0]       c0_mem_addr,
  input  logic [15:0]      c0_mem_din,
  output logic [15:0]      c0_mem_dout,
  output logic             c0_mem_done,
  input  logic             c1_mem_rd,
  input  logic             c1_mem_wr,
  input  logic [4:0]       c1_mem_addr,
  input  logic [15:0]      c1_mem_din,
  output logic [15:0]      c1_mem_dout,
  output logic             c1_mem_done,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [4:0]       mem_addr,
  output logic [15:0]      mem_din,
  input  logic [15:0]      mem_dout,
  input  logic             mem_done,
  output logic             grant_id,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam int               WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic             memRd_q, memRd_d;
  logic             memWr_q, memWr_d;
  logic [4:0]       memAddr_q, memAddr_d;
  logic [15:0]      memDin_q, memDin_d;
  logic             grantId_q, grantId_d;
  logic             prio_q, prio_d;
  logic [WD_W-1:0]  wdCnt_q, wdCnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] gntCnt0_q, gntCnt0_d;
  logic [CNT_W-1:0] gntCnt1_q, gntCnt1_d;
  logic             req0, req1, winner;

  always_comb begin
    state_d   = state_q;
    memRd_d   = memRd_q;
    memWr_d   = memWr_q;
    memAddr_d = memAddr_q;
    memDin_d  = memDin_q;
    grantId_d = grantId_q;
    prio_d    = prio_q;
    wdCnt_d   = wdCnt_q;
    timeout_d = timeout_q;
    gntCnt0_d = gntCnt0_q;
    gntCnt1_d = gntCnt1_q;
    req0      = c0_mem_rd | c0_mem_wr;
    req1      = c1_mem_rd | c1_mem_wr;
    // A lone requester always wins; on a tie the pointer (0 = favour c0) decides.
    winner    = req1 & (~req0 | prio_q);

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d   = BUSY;
          grantId_d = winner;
          wdCnt_d   = '0;
          // Write wins when a requester raises rd and wr together.
          if (winner) begin
            memWr_d   = c1_mem_wr;
            memRd_d   = c1_mem_rd & ~c1_mem_wr;
            memAddr_d = c1_mem_addr;
            memDin_d  = c1_mem_din;
            if (gntCnt1_q != CNT_MAX) gntCnt1_d = gntCnt1_q + CNT_W'(1);
          end else begin
            memWr_d   = c0_mem_wr;
            memRd_d   = c0_mem_rd & ~c0_mem_wr;
            memAddr_d = c0_mem_addr;
            memDin_d  = c0_mem_din;
            if (gntCnt0_q != CNT_MAX) gntCnt0_d = gntCnt0_q + CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (mem_done) begin
          state_d = IDLE;
          memRd_d = 1'b0;
          memWr_d = 1'b0;
          prio_d  = ~grantId_q;
        end else if (wdCnt_q != WD_LIMIT) begin
          // With TIMEOUT_CYCLES of 0 the limit is 0, so the watchdog never advances.
          wdCnt_d = wdCnt_q + WD_W'(1);
          if (wdCnt_d == WD_LIMIT) timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      memRd_q   <= 1'b0;
      memWr_q   <= 1'b0;
      memAddr_q <= '0;
      memDin_q  <= '0;
      grantId_q <= 1'b0;
      prio_q    <= 1'b0;
      wdCnt_q   <= '0;
      timeout_q <= 1'b0;
      gntCnt0_q <= '0;
      gntCnt1_q <= '0;
    end else begin
      state_q   <= state_d;
      memRd_q   <= memRd_d;
      memWr_q   <= memWr_d;
      memAddr_q <= memAddr_d;
      memDin_q  <= memDin_d;
      grantId_q <= grantId_d;
      prio_q    <= prio_d;
      wdCnt_q   <= wdCnt_d;
      timeout_q <= timeout_d;
      gntCnt0_q <= gntCnt0_d;
      gntCnt1_q <= gntCnt1_d;
    end
  end

  assign busy        = (state_q == BUSY);
  assign mem_rd      = memRd_q;
  assign mem_wr      = memWr_q;
  assign mem_addr    = memAddr_q;
  assign mem_din     = memDin_q;
  assign grant_id    = grantId_q;
  assign timeout_err = timeout_q;
  assign gnt_cnt0    = gntCnt0_q;
  assign gnt_cnt1    = gntCnt1_q;
  assign c0_mem_done = mem_done & busy & ~grantId_q;
  assign c1_mem_done = mem_done & busy & grantId_q;
  assign c0_mem_dout = mem_dout;
  assign c1_mem_dout = mem_dout;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Self-checking bench for mem_arbiter_2to1: directed scenarios followed by a randomized run
// that is checked against a queue-based model of the two requesters and the memory.
module tb_mem_arbiter_2to1;

  localparam int TIMEOUT = 64;
  localparam int CW      = 2;

  typedef struct packed {
    logic [1:0]  kind;   // 0 = read, 1 = write, 2 = read and write together
    logic [4:0]  addr;
    logic [15:0] din;
  } op_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    reqRd, reqWr;
  logic [4:0]    reqAddr [2];
  logic [15:0]   reqDin [2];
  logic [15:0]   dout0, dout1;
  logic          done0, done1;
  logic          memRd, memWr, memDone;
  logic [4:0]    memAddr;
  logic [15:0]   memDin, memDout;
  logic          grantId, busy, timeoutErr;
  logic [CW-1:0] cnt0, cnt1;

  int          testsRun = 0;
  int          testsFailed = 0;
  op_t         q0[$], q1[$];
  logic [15:0] memModel [32];
  bit   [1:0]  on;
  int          fav, winner, waited;
  int          grants [2];

  mem_arbiter_2to1 #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .c0_mem_rd(reqRd[0]), .c0_mem_wr(reqWr[0]), .c0_mem_addr(reqAddr[0]), .c0_mem_din(reqDin[0]),
    .c0_mem_dout(dout0), .c0_mem_done(done0),
    .c1_mem_rd(reqRd[1]), .c1_mem_wr(reqWr[1]), .c1_mem_addr(reqAddr[1]), .c1_mem_din(reqDin[1]),
    .c1_mem_dout(dout1), .c1_mem_done(done1),
    .mem_rd(memRd), .mem_wr(memWr), .mem_addr(memAddr), .mem_din(memDin),
    .mem_dout(memDout), .mem_done(memDone),
    .grant_id(grantId), .busy(busy), .timeout_err(timeoutErr),
    .gnt_cnt0(cnt0), .gnt_cnt1(cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic int sat(input int n);
    int m = (1 << CW) - 1;
    return (n > m) ? m : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input int n, input op_t op);
    reqRd[n]   = (op.kind != 2'd1);
    reqWr[n]   = (op.kind != 2'd0);
    reqAddr[n] = op.addr;
    reqDin[n]  = op.din;
  endtask

  task automatic applyReset();
    reset   = 1'b1;
    reqRd   = 2'b00;
    reqWr   = 2'b00;
    memDone = 1'b0;
    memDout = 16'h0000;
    for (int n = 0; n < 2; n++) begin
      reqAddr[n] = 5'h00;
      reqDin[n]  = 16'h0000;
    end
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rstRd",      32'(memRd), 32'(0));
    checkOutput("rstWr",      32'(memWr), 32'(0));
    checkOutput("rstAddr",    32'(memAddr), 32'(0));
    checkOutput("rstDin",     32'(memDin), 32'(0));
    checkOutput("rstGrant",   32'(grantId), 32'(0));
    checkOutput("rstBusy",    32'(busy), 32'(0));
    checkOutput("rstTimeout", 32'(timeoutErr), 32'(0));
    checkOutput("rstCnt0",    32'(cnt0), 32'(0));
    checkOutput("rstCnt1",    32'(cnt1), 32'(0));
  endtask

  // Plays the memory for one transaction: waits for the grant, holds for lat cycles, pulses done.
  task automatic serveOne(input int expId, input logic expWr, input logic [4:0] expAddr,
                          input logic [15:0] expDin, input int lat, input logic [15:0] rdata,
                          input bit dropAtDone, output int waitCycles);
    waitCycles = 0;
    while (!(memRd || memWr) && waitCycles < 40) begin
      tick();
      waitCycles++;
    end
    checkOutput("grantSeen", 32'(memRd | memWr), 32'(1));
    checkOutput("grantId",   32'(grantId), 32'(expId));
    checkOutput("memWr",     32'(memWr), 32'(expWr));
    checkOutput("memRd",     32'(memRd), 32'(!expWr));
    checkOutput("memAddr",   32'(memAddr), 32'(expAddr));
    if (expWr) checkOutput("memDin", 32'(memDin), 32'(expDin));
    checkOutput("busyHigh",  32'(busy), 32'(1));
    for (int i = 0; i < lat; i++) begin
      tick();
      checkOutput("holdRdWr",    32'({memRd, memWr}), 32'({!expWr, expWr}));
      checkOutput("holdAddr",    32'(memAddr), 32'(expAddr));
      checkOutput("noEarlyDone", 32'({done1, done0}), 32'(0));
    end
    memDone = 1'b1;
    memDout = rdata;
    #1;
    checkOutput("doneOwner", 32'(expId != 0 ? done1 : done0), 32'(1));
    checkOutput("doneOther", 32'(expId != 0 ? done0 : done1), 32'(0));
    checkOutput("dout0",     32'(dout0), 32'(rdata));
    checkOutput("dout1",     32'(dout1), 32'(rdata));
    if (dropAtDone) begin
      reqRd[expId] = 1'b0;
      reqWr[expId] = 1'b0;
    end
    tick();
    memDone = 1'b0;
    checkOutput("postDoneRdWr", 32'({memRd, memWr}), 32'(0));
    checkOutput("postDoneBusy", 32'(busy), 32'(0));
    checkOutput("keepAddr",     32'(memAddr), 32'(expAddr));
    checkOutput("keepGrant",    32'(grantId), 32'(expId));
  endtask

  // Raises the head request of any idle requester with work left, at least one if possible.
  task automatic refreshPresent();
    if (!on[0] && q0.size() > 0 && $urandom_range(0, 3) != 0) begin
      applyStimulus(0, q0[0]);
      on[0] = 1'b1;
    end
    if (!on[1] && q1.size() > 0 && $urandom_range(0, 3) != 0) begin
      applyStimulus(1, q1[0]);
      on[1] = 1'b1;
    end
    if (on == 2'b00) begin
      if (q0.size() > 0) begin
        applyStimulus(0, q0[0]);
        on[0] = 1'b1;
      end else if (q1.size() > 0) begin
        applyStimulus(1, q1[0]);
        on[1] = 1'b1;
      end
    end
  endtask

  initial begin
    op_t         op;
    logic        expWr;
    logic [15:0] rdata;

    // Single read with a three-cycle memory, then a stray done while idle.
    applyReset();
    applyStimulus(0, '{kind: 2'd0, addr: 5'h0A, din: 16'h0000});
    serveOne(0, 1'b0, 5'h0A, 16'h0000, 3, 16'hBEEF, 1'b1, waited);
    checkOutput("readLatency", 32'(waited), 32'(1));
    checkOutput("readCnt0", 32'(cnt0), 32'(1));
    checkOutput("readCnt1", 32'(cnt1), 32'(0));
    checkOutput("readDoneOnce", 32'({done1, done0}), 32'(0));
    memDone = 1'b1;
    #1;
    checkOutput("idleDoneIgnored", 32'({done1, done0}), 32'(0));
    tick();
    memDone = 1'b0;
    checkOutput("idleStays", 32'({busy, memRd, memWr}), 32'(0));

    // Simultaneous requests after reset: c0 first, c1 at M+2, then c0 favoured again.
    applyReset();
    applyStimulus(0, '{kind: 2'd0, addr: 5'h01, din: 16'h0000});
    applyStimulus(1, '{kind: 2'd1, addr: 5'h02, din: 16'h1234});
    serveOne(0, 1'b0, 5'h01, 16'h0000, 1, 16'h1111, 1'b1, waited);
    serveOne(1, 1'b1, 5'h02, 16'h1234, 2, 16'h2222, 1'b1, waited);
    checkOutput("simulC1Latency", 32'(waited), 32'(1));
    applyStimulus(0, '{kind: 2'd0, addr: 5'h04, din: 16'h0000});
    applyStimulus(1, '{kind: 2'd0, addr: 5'h05, din: 16'h0000});
    serveOne(0, 1'b0, 5'h04, 16'h0000, 0, 16'h3333, 1'b1, waited);
    serveOne(1, 1'b0, 5'h05, 16'h0000, 0, 16'h4444, 1'b1, waited);

    // Fairness with both requesters holding their levels throughout.
    applyReset();
    applyStimulus(0, '{kind: 2'd0, addr: 5'h10, din: 16'h0000});
    applyStimulus(1, '{kind: 2'd1, addr: 5'h11, din: 16'hCAFE});
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) serveOne(0, 1'b0, 5'h10, 16'h0000, 1, 16'h00A0, 1'b0, waited);
      else            serveOne(1, 1'b1, 5'h11, 16'hCAFE, 1, 16'h00A1, 1'b0, waited);
      checkOutput("fairLatency", 32'(waited), 32'(1));
    end
    checkOutput("fairCnt0", 32'(cnt0), 32'(3));
    checkOutput("fairCnt1", 32'(cnt1), 32'(3));
    reqRd = 2'b00;
    reqWr = 2'b00;
    tick();

    // Flush then fetch on c1 while c0 waits in between.
    applyReset();
    applyStimulus(1, '{kind: 2'd1, addr: 5'h07, din: 16'hAAAA});
    tick();
    applyStimulus(0, '{kind: 2'd0, addr: 5'h08, din: 16'h0000});
    serveOne(1, 1'b1, 5'h07, 16'hAAAA, 2, 16'h0000, 1'b0, waited);
    applyStimulus(1, '{kind: 2'd0, addr: 5'h09, din: 16'h0000});
    serveOne(0, 1'b0, 5'h08, 16'h0000, 1, 16'h5555, 1'b1, waited);
    checkOutput("flushC0Latency", 32'(waited), 32'(1));
    serveOne(1, 1'b0, 5'h09, 16'h0000, 1, 16'h6666, 1'b1, waited);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("noDupWrite", 32'({memRd, memWr}), 32'(0));
    end
    checkOutput("flushCnt0", 32'(cnt0), 32'(1));
    checkOutput("flushCnt1", 32'(cnt1), 32'(2));

    // rd and wr together issue a write; the 2-bit grant counter saturates at 3.
    applyReset();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, '{kind: 2'd2, addr: 5'h1F, din: 16'h5A50 + 16'(k)});
      serveOne(0, 1'b1, 5'h1F, 16'h5A50 + 16'(k), 1, 16'h0000, 1'b1, waited);
      checkOutput("satCnt0", 32'(cnt0), 32'(sat(k)));
    end

    // Watchdog on a memory that never answers, then reset in mid-transaction.
    applyReset();
    applyStimulus(0, '{kind: 2'd0, addr: 5'h03, din: 16'h0000});
    tick();
    checkOutput("wdGrant", 32'(memRd), 32'(1));
    for (int k = 1; k <= 70; k++) begin
      tick();
      checkOutput("wdFlag", 32'(timeoutErr), 32'(k >= TIMEOUT));
    end
    checkOutput("wdStillRd", 32'(memRd), 32'(1));
    checkOutput("wdStillBusy", 32'(busy), 32'(1));
    reset = 1'b1;
    tick();
    checkOutput("midRstRdWr",    32'({memRd, memWr}), 32'(0));
    checkOutput("midRstAddr",    32'(memAddr), 32'(0));
    checkOutput("midRstBusy",    32'(busy), 32'(0));
    checkOutput("midRstTimeout", 32'(timeoutErr), 32'(0));
    checkOutput("midRstCnt0",    32'(cnt0), 32'(0));
    memDone = 1'b1;
    #1;
    checkOutput("midRstNoDone", 32'({done1, done0}), 32'(0));
    memDone = 1'b0;
    reqRd   = 2'b00;
    reset   = 1'b0;
    tick();

    // Randomized traffic against the requester queues and a memory image.
    applyReset();
    fav = 0;
    grants[0] = 0;
    grants[1] = 0;
    on = 2'b00;
    for (int i = 0; i < 32; i++) memModel[i] = 16'($urandom);
    for (int i = 0; i < 12; i++) begin
      op.kind = 2'($urandom_range(0, 2));
      op.addr = 5'($urandom);
      op.din  = 16'($urandom);
      q0.push_back(op);
      op.kind = 2'($urandom_range(0, 2));
      op.addr = 5'($urandom);
      op.din  = 16'($urandom);
      q1.push_back(op);
    end
    refreshPresent();
    while (on != 2'b00) begin
      winner = (on == 2'b11) ? fav : (on[0] ? 0 : 1);
      op     = (winner != 0) ? q1[0] : q0[0];
      expWr  = (op.kind != 2'd0);
      rdata  = expWr ? 16'($urandom) : memModel[op.addr];
      serveOne(winner, expWr, op.addr, op.din, int'($urandom_range(0, 3)), rdata, 1'b1, waited);
      checkOutput("rndLatency", 32'(waited), 32'(1));
      if (expWr) memModel[op.addr] = op.din;
      if (winner != 0) void'(q1.pop_front());
      else             void'(q0.pop_front());
      on[winner] = 1'b0;
      grants[winner]++;
      fav = 1 - winner;
      checkOutput("rndCnt0", 32'(cnt0), 32'(sat(grants[0])));
      checkOutput("rndCnt1", 32'(cnt1), 32'(sat(grants[1])));
      refreshPresent();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
